// File: rtl/core_pkg.sv
// Shared core definitions: address width, PC increment, reset vector and the
// next-PC source select used by next_pc_gen.
package core_pkg;

  localparam int WIDTH = 32;
  localparam int PC_INC = 4;
  localparam logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_RET,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } npc_sel_t;

endpackage

// File: rtl/next_pc_gen_if.sv
// Control/target bundle between the core and the next-PC generator.
// All signals are level-sampled each cycle; there is no valid/ready handshake.
interface next_pc_gen_if #(
  parameter int WIDTH = 32,
  parameter int RAS_DEPTH = 4
);

  logic [WIDTH-1:0] pc_in;
  logic stall;
  logic branch_taken;
  logic [WIDTH-1:0] branch_offset;
  logic jump;
  logic call;
  logic [WIDTH-1:0] jump_target;
  logic ret;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] next_pc;
  logic ras_empty;
  logic ras_full;
  logic [$clog2(RAS_DEPTH):0] ras_count;

  modport master (
    output pc_in, stall, branch_taken, branch_offset, jump, call,
           jump_target, ret, ret_target,
    input  next_pc, ras_empty, ras_full, ras_count
  );

  modport slave (
    input  pc_in, stall, branch_taken, branch_offset, jump, call,
           jump_target, ret, ret_target,
    output next_pc, ras_empty, ras_full, ras_count
  );

endinterface

// File: rtl/next_pc_gen_ras_stack.sv
// Circular return-address stack: top pointer plus saturating count. When full,
// a push overwrites the oldest entry. Entry storage is not reset.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pop has priority; popping an empty stack is a no-op.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && !pop;

  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    if (do_pop) begin
      tp_d    = tp_q - 1'b1;
      count_d = count_q - 1'b1;
    end else if (do_push) begin
      tp_d = tp_q + 1'b1;
      if (count_q != CW'(DEPTH)) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      tp_q    <= '0;
      count_q <= '0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear && do_push) mem_q[tp_d] <= push_data;
  end

  assign top   = mem_q[tp_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/next_pc_gen.sv
// Next-PC generator: priority select over reset/hold/return/jump/branch/+4.
// Return-address stack is built only when NEXT_PC_RAS_EN is defined.
module next_pc_gen #(
  parameter int WIDTH = core_pkg::WIDTH,
  parameter int RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(core_pkg::RESET_VECTOR)
) (
  input logic            clock,
  input logic            reset,
  next_pc_gen_if.slave   bus
);

  import core_pkg::*;

  npc_sel_t         sel;
  logic [WIDTH-1:0] pc_plus_inc;
  logic [WIDTH-1:0] branch_pc;
  logic [WIDTH-1:0] ret_pc;

  assign pc_plus_inc = bus.pc_in + WIDTH'(PC_INC);
  assign branch_pc   = bus.pc_in + bus.branch_offset;

  always_comb begin
    sel = SEL_SEQ;
    if (reset)                      sel = SEL_RESET;
    else if (bus.stall)             sel = SEL_HOLD;
    else if (bus.ret)               sel = SEL_RET;
    else if (bus.call || bus.jump)  sel = SEL_JUMP;
    else if (bus.branch_taken)      sel = SEL_BRANCH;
  end

`ifdef NEXT_PC_RAS_EN
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;

  // Reset and stall both land outside SEL_RET/SEL_JUMP, so they block stack updates.
  assign ras_push = (sel == SEL_JUMP) && bus.call;
  assign ras_pop  = (sel == SEL_RET);

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .clear     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus_inc),
    .top       (ras_top),
    .empty     (bus.ras_empty),
    .full      (bus.ras_full),
    .count     (bus.ras_count)
  );

  assign ret_pc = bus.ras_empty ? bus.ret_target : ras_top;
`else
  logic unused_clock;

  assign unused_clock  = clock;
  assign ret_pc        = bus.ret_target;
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_count = '0;
`endif

  always_comb begin
    bus.next_pc = pc_plus_inc;
    unique case (sel)
      SEL_RESET:  bus.next_pc = RESET_VECTOR;
      SEL_HOLD:   bus.next_pc = bus.pc_in;
      SEL_RET:    bus.next_pc = ret_pc;
      SEL_JUMP:   bus.next_pc = bus.jump_target;
      SEL_BRANCH: bus.next_pc = branch_pc;
      default:    bus.next_pc = pc_plus_inc;
    endcase
  end

endmodule

// File: doc/next_pc_gen.md
# next_pc_gen

Next-PC generator for the single-cycle core: it drives the `nextPC` input of the PC register every cycle. It selects among sequential (+4), conditional-branch, jump/call and return targets. It holds a small circular return-address stack (RAS) that is pushed on calls and popped on returns. It also forces the reset vector, because the PC register itself has no reset.

## Interface
- `WIDTH`, 32, address width in bits
- `RAS_DEPTH`, 4, return-stack entries (power of two, ≥2)
- `RESET_VECTOR`, 32'h0000_0000, address the core starts fetching from
- `clock`  in  1  rising-edge clock, shared with the PC register
- `reset`  in  1  synchronous, active-high
- `pc_in`  in  WIDTH  current PC (PC register output)
- `stall`  in  1  hold PC, no RAS change
- `branch_taken`  in  1  conditional branch resolved taken
- `branch_offset`  in  WIDTH  sign-extended byte offset, relative to `pc_in`
- `jump`  in  1  unconditional jump to `jump_target`
- `call`  in  1  jump to `jump_target` and push `pc_in+4`
- `jump_target`  in  WIDTH  absolute target for `jump`/`call`
- `ret`  in  1  return
- `ret_target`  in  WIDTH  architectural return address (register operand)
- `next_pc`  out  WIDTH  value the PC register loads at the next edge
- `ras_empty`  out  1  stack holds no entries
- `ras_full`  out  1  stack holds `RAS_DEPTH` entries
- `ras_count`  out  $clog2(RAS_DEPTH)+1  number of valid entries

## Operation
- `next_pc` is combinational. Priority, highest first:
  - `reset` → `RESET_VECTOR`
  - `stall` → `pc_in`
  - `ret` → RAS top if non-empty, else `ret_target`
  - `call` or `jump` → `jump_target`
  - `branch_taken` → `pc_in+branch_offset`
  - otherwise → `pc_in+4`
- All additions are modulo 2^WIDTH; a carry out is discarded and is not an error.
- RAS is a circular buffer with a top pointer `tp` and a saturating count.
  - Push (`call`, not stalled, `ret` low): write `pc_in+4` at `tp+1` and advance `tp`. The count saturates at `RAS_DEPTH`. When full, the oldest entry is silently overwritten.
  - Pop (`ret`, not stalled, count>0): decrement `tp` and decrement the count.
  - `ret` with an empty stack: no state change, and `next_pc=ret_target`.
- `call` and `ret` in the same cycle: `ret` wins. No push occurs, and `next_pc` follows the `ret` rule.
- `jump`, `branch_taken` or no control input: the RAS is untouched. Lower-priority inputs are ignored whenever a higher one is active.

## Timing
- Zero-cycle latency from the inputs to `next_pc`. RAS updates take effect at the rising edge.
- Reset, synchronous:
  - While `reset`=1: `next_pc=RESET_VECTOR`, no push or pop.
  - At the edge: count←0, `tp`←0, `ras_empty`=1, `ras_full`=0, `ras_count`=0.
  - Entry contents are don't-care and need no reset.
- Reset asserted mid-call/ret: reset wins, the stack is cleared, and the pending push/pop is dropped.
- A push followed on the next cycle by a pop returns the address pushed one edge earlier.
- Stall held for N cycles: `next_pc=pc_in` for all N cycles and the RAS is frozen. A control input present during a stall is not remembered.

## Configuration
- `NEXT_PC_RAS_EN` defined: the RAS is built as described.
- Undefined:
  - No storage is built.
  - `ret` always selects `ret_target`.
  - `call` behaves like `jump`.
  - `ras_empty`=1, `ras_full`=0 and `ras_count`=0 permanently.
- The priority order is identical in both builds.

## Structure
- Shared package `core_pkg` holds:
  - `WIDTH`
  - `PC_INC`=4
  - `RESET_VECTOR`
  - the `npc_sel_t` enum (`SEL_RESET`, `SEL_HOLD`, `SEL_RET`, `SEL_JUMP`, `SEL_BRANCH`, `SEL_SEQ`)
- One sub-module, `ras_stack`: circular storage, pointer and count, with a push/pop/clear interface and `top`, `empty`, `full` and `count` outputs.
- The top level holds the priority select and the adders.

## Test plan
- Reset: `reset`=1 with `pc_in`=32'h40 → `next_pc`=0. After release with no controls → `next_pc`=32'h44, and `ras_empty`=1.
- Branch wrap: `pc_in`=32'hFFFF_FFFC with `branch_offset`=8 → `next_pc`=32'h4. With `branch_offset`=32'hFFFF_FFF0 at `pc_in`=32'h100 → `next_pc`=32'hF0.
- Call/ret: `call` at `pc_in`=32'h200 with `jump_target`=32'h800 → `next_pc`=32'h800 and `ras_count`=1. Then `ret` with `ret_target`=32'hDEAD → `next_pc`=32'h204 and `ras_count`=0.
- Overflow: 5 calls at PCs 0x10, 0x20, 0x30, 0x40, 0x50 with depth 4 → `ras_full`=1. Four rets then yield 0x54, 0x44, 0x34, 0x24. A fifth ret with `ret_target`=32'h99 yields 0x99.
- Stall/priority: `stall`+`call` → `next_pc`=`pc_in` and `ras_count` unchanged. `call`+`ret` → pop only, no push. `jump`+`branch_taken` → `jump_target`.
- Config-off build: `call` at 32'h200 then `ret` with `ret_target`=32'h300 → `next_pc`=32'h300, and `ras_count` stays 0.
